// File: rtl/riscv_imm_pkg.sv
// Shared immediate-type encodings, per-type immediate field masks and range limits
// for the RISC-V immediate encoder. Range limits are consumed when IMM_RANGE_CHECK_EN is defined.
package riscv_imm_pkg;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [31:0] MASK_I = 32'hFFF0_0000;
    localparam logic [31:0] MASK_S = 32'hFE00_0F80;
    localparam logic [31:0] MASK_B = MASK_S;
    localparam logic [31:0] MASK_J = 32'hFFFF_F000;

    localparam logic signed [31:0] I_MIN = -32'sd2048;
    localparam logic signed [31:0] I_MAX = 32'sd2047;
    localparam logic signed [31:0] B_MIN = -32'sd4096;
    localparam logic signed [31:0] B_MAX = 32'sd4094;
    localparam logic signed [31:0] J_MIN = -32'sd1048576;
    localparam logic signed [31:0] J_MAX = 32'sd1048574;

    function automatic logic [31:0] field_mask(input logic [1:0] immsrc);
        case (immsrc)
            IMM_I:   field_mask = MASK_I;
            IMM_S:   field_mask = MASK_S;
            IMM_B:   field_mask = MASK_B;
            default: field_mask = MASK_J;
        endcase
    endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational immediate scatter: clears the type's immediate field in base and ORs in the packed
// immediate. The range/alignment checker exists only when IMM_RANGE_CHECK_EN is defined.
module imm_pack
    import riscv_imm_pkg::*;
(
    input  logic [31:0] base,
    input  logic [31:0] imm,
    input  logic [1:0]  immsrc,
    output logic [31:0] instr,
    output logic        err
);

    logic [31:0] field;

    always_comb begin
        field = '0;
        case (immsrc)
            IMM_I:   field = {imm[11:0], 20'b0};
            IMM_S:   field = {imm[11:5], 13'b0, imm[4:0], 7'b0};
            IMM_B:   field = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
            default: field = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
        endcase
        instr = (base & ~field_mask(immsrc)) | field;
    end

`ifdef IMM_RANGE_CHECK_EN
    logic signed [31:0] simm;
    assign simm = $signed(imm);

    always_comb begin
        err = 1'b0;
        case (immsrc)
            IMM_I, IMM_S: err = (simm < I_MIN) || (simm > I_MAX);
            IMM_B:        err = (simm < B_MIN) || (simm > B_MAX) || imm[0];
            default:      err = (simm < J_MIN) || (simm > J_MAX) || imm[0];
        endcase
    end
`else
    // Without the checker the high immediate bits and imm[0] are intentionally discarded.
    logic unused_imm;
    assign unused_imm = ^{imm[31:21], imm[0]};
    assign err        = 1'b0;
`endif

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready pipeline around imm_pack with a saturating error counter.
// Define IMM_RANGE_CHECK_EN to enable range checking, out_err and err_count.
module imm_encoder
    import riscv_imm_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_base,
    input  logic [31:0]      in_imm,
    input  logic [1:0]       in_immsrc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] err_count
);

    logic        s1_v;
    logic [31:0] s1_base;
    logic [31:0] s1_imm;
    logic [1:0]  s1_src;
    logic        s2_load;
    logic        in_fire;
    logic [31:0] pack_instr;
    logic        pack_err;

    assign s2_load  = !out_valid || out_ready;
    assign in_ready = reset_n && (!s1_v || s2_load);
    assign in_fire  = in_valid && in_ready;

    imm_pack u_pack (
        .base   (s1_base),
        .imm    (s1_imm),
        .immsrc (s1_src),
        .instr  (pack_instr),
        .err    (pack_err)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_v    <= 1'b0;
            s1_base <= '0;
            s1_imm  <= '0;
            s1_src  <= IMM_I;
        end else if (in_fire) begin
            s1_v    <= 1'b1;
            s1_base <= in_base;
            s1_imm  <= in_imm;
            s1_src  <= in_immsrc;
        end else if (s2_load) begin
            s1_v <= 1'b0;
        end
    end

    // Data only moves on a real word so out_instr/out_err hold across bubbles and stalls.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_err   <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_v;
            if (s1_v) begin
                out_instr <= pack_instr;
                out_err   <= pack_err;
            end
        end
    end

`ifdef IMM_RANGE_CHECK_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_count <= '0;
        end else if (out_valid && out_ready && out_err && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
        end
    end
`else
    assign err_count = '0;
`endif

endmodule
